fifo_wptr_ctrl: RTL and testbench

FIFO_WPTR_CTRL -- requirements
Module: fifo_wptr_ctrl

---
 rtl/fifo_wptr_ctrl.sv | 136 +++++++++++++
 tb/tb_fifo_wptr_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for an async FIFO: accepts writes and exports the Gray pointer.
// Optional almost_full output enabled by defining FIFO_WPTR_CTRL_ALMOST_FULL_EN.
module fifo_wptr_ctrl #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W:0]   rd_gray_async,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wr_gray,
    output logic              full
`ifdef FIFO_WPTR_CTRL_ALMOST_FULL_EN
    ,
    output logic              almost_full
`endif
);

    localparam int P = ADDR_W + 1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           init_cnt;
    logic           init_cnt_next;
    logic [P-1:0]   wbin;
    logic [P-1:0]   wbin_next;
    logic [P-1:0]   wgray_next;
    logic [P-1:0]   rq1;
    logic [P-1:0]   rq2;
    logic [P-1:0]   full_cmp;
    logic           run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= 1'b0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        unique case (state)
            INIT: begin
                if (init_cnt) begin
                    state_next    = RUN;
                    init_cnt_next = 1'b0;
                end else begin
                    init_cnt_next = 1'b1;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign run = (state == RUN);

    // rst gates the ack so an in-flight request is never written on the reset cycle
    assign wr_ack     = wr_req & ~full & run & ~rst;
    assign wbin_next  = wbin + P'(wr_ack);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign wr_addr    = wbin[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rd_gray_async;
            rq2 <= rq1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin    <= '0;
            wr_gray <= '0;
        end else begin
            wbin    <= wbin_next;
            wr_gray <= wgray_next;
        end
    end

    // Full when the write pointer laps the read pointer: top two Gray bits inverted
    assign full_cmp = {~rq2[P-1:P-2], rq2[P-3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b1;
        end else if (state_next == RUN) begin
            full <= (wgray_next == full_cmp);
        end else begin
            full <= 1'b1;
        end
    end

`ifdef FIFO_WPTR_CTRL_ALMOST_FULL_EN
    logic [P-1:0] rbin;
    logic [P-1:0] level;

    always_comb begin
        rbin       = '0;
        rbin[P-1]  = rq2[P-1];
        for (int i = P - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rq2[i];
        end
    end

    assign level = wbin_next - rbin;

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else if (state_next == RUN) begin
            almost_full <= (level >= P'((2 ** ADDR_W) - 1));
        end else begin
            almost_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for fifo_wptr_ctrl: vector table plus reset, wrap and almost-full sequences.
module tb_fifo_wptr_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_req;
    logic [3:0] rd_gray_async;
    logic       wr_ack;
    logic [2:0] wr_addr;
    logic [3:0] wr_gray;
    logic       full;
`ifdef FIFO_WPTR_CTRL_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    fifo_wptr_ctrl #(.ADDR_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_req        (wr_req),
        .rd_gray_async (rd_gray_async),
        .wr_ack        (wr_ack),
        .wr_addr       (wr_addr),
        .wr_gray       (wr_gray),
        .full          (full)
`ifdef FIFO_WPTR_CTRL_ALMOST_FULL_EN
        ,
        .almost_full   (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       req;
        logic [3:0] rd;
        logic       chk;
        logic       ack;
        logic [2:0] addr;
        logic [3:0] gray;
        logic       full;
    } vec_t;

    vec_t vt[19];

    function automatic logic [3:0] gray_of(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic q, input logic [3:0] rd);
        @(negedge clk);
        rst           = r;
        wr_req        = q;
        rd_gray_async = rd;
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] cur;
        logic [3:0] rdv;

        rst           = 1'b1;
        wr_req        = 1'b0;
        rd_gray_async = 4'h0;

        vt[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1};
        vt[1]  = '{1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd0, 4'b0000, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd1, 4'b0001, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd2, 4'b0011, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd3, 4'b0010, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd4, 4'b0110, 1'b0};
        vt[10] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd5, 4'b0111, 1'b0};
        vt[11] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd6, 4'b0101, 1'b0};
        vt[12] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 3'd7, 4'b0100, 1'b0};
        vt[13] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1};
        vt[14] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1};
        vt[15] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1};
        vt[16] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1};
        vt[17] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 3'd0, 4'b1100, 1'b0};
        vt[18] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 3'd1, 4'b1101, 1'b1};

        for (int i = 0; i < 19; i++) begin
            step(vt[i].rst, vt[i].req, vt[i].rd);
            if (vt[i].chk) begin
                check("vec_ack",  i, 32'(wr_ack),  32'(vt[i].ack));
                check("vec_addr", i, 32'(wr_addr), 32'(vt[i].addr));
                check("vec_gray", i, 32'(wr_gray), 32'(vt[i].gray));
                check("vec_full", i, 32'(full),    32'(vt[i].full));
            end
        end

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'h0);
            check("mid_pre_ack", i, 32'(wr_ack), 32'd1);
        end
        step(1'b1, 1'b1, 4'h0);
        check("mid_rst_ack", 0, 32'(wr_ack), 32'd0);
        step(1'b0, 1'b1, 4'h0);
        check("mid_gray", 0, 32'(wr_gray), 32'd0);
        check("mid_addr", 0, 32'(wr_addr), 32'd0);
        check("mid_full", 0, 32'(full),    32'd1);
        check("mid_ack",  0, 32'(wr_ack),  32'd0);
        step(1'b0, 1'b1, 4'h0);
        check("mid_full", 1, 32'(full),   32'd1);
        check("mid_ack",  1, 32'(wr_ack), 32'd0);
        step(1'b0, 1'b1, 4'h0);
        check("mid_full", 2, 32'(full),   32'd0);
        check("mid_ack",  2, 32'(wr_ack), 32'd1);

        do_reset();
        prev = 4'h0;
        for (int i = 0; i <= 16; i++) begin
            cur = 4'(i);
            rdv = (i >= 2) ? gray_of(4'(i - 2)) : 4'h0;
            step(1'b0, 1'b1, rdv);
            check("wrap_ack",  i, 32'(wr_ack),  32'd1);
            check("wrap_full", i, 32'(full),    32'd0);
            check("wrap_addr", i, 32'(wr_addr), 32'(cur[2:0]));
            check("wrap_gray", i, 32'(wr_gray), 32'(gray_of(cur)));
            if (i > 0)
                check("wrap_onebit", i, 32'($countones(wr_gray ^ prev)), 32'd1);
            prev = wr_gray;
        end

`ifdef FIFO_WPTR_CTRL_ALMOST_FULL_EN
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 4'h0);
            check("af_low", i, 32'(almost_full), 32'd0);
            check("af_ack", i, 32'(wr_ack),      32'd1);
        end
        step(1'b0, 1'b0, 4'h0);
        check("af_high", 0, 32'(almost_full), 32'd1);
        check("af_full", 0, 32'(full),        32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
